// File: rtl/rotate_finder.sv
// rotate_finder: finds the smallest rotation mapping original onto rotated, one position per clock
module rotate_finder #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] original,
   input  logic [WIDTH-1:0] rotated,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [SHW-1:0]   shift,
   output logic             lr
);
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
   localparam logic [SHW-1:0] KMAX = SHW'(WIDTH - 1);
   localparam logic [SHW-1:0] HALF = SHW'(WIDTH / 2);
   state_t state, state_n;
   logic [WIDTH-1:0] cur, cur_n, tgt, tgt_n;
   logic [SHW-1:0] k, k_n, shift_n;
   logic found_n, lr_n;
   always_comb begin
      state_n = state;
      cur_n   = cur;
      tgt_n   = tgt;
      k_n     = k;
      found_n = found;
      shift_n = shift;
      lr_n    = lr;
      case (state)
         IDLE: if (start) begin
            state_n = SEARCH;
            cur_n   = original;
            tgt_n   = rotated;
            k_n     = '0;
            found_n = 1'b0;
            shift_n = '0;
            lr_n    = 1'b0;
         end
         SEARCH: if (cur == tgt) begin
            state_n = DONE;
            found_n = 1'b1;
            lr_n    = k > HALF;
            shift_n = (k > HALF) ? SHW'(-k) : k;
         end else if (k == KMAX) begin
            state_n = DONE;
            found_n = 1'b0;
            shift_n = '0;
            lr_n    = 1'b0;
         end else begin
            cur_n = {cur[WIDTH-2:0], cur[WIDTH-1]};
            k_n   = k + 1'b1;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cur   <= '0;
         tgt   <= '0;
         k     <= '0;
         found <= 1'b0;
         shift <= '0;
         lr    <= 1'b0;
      end else begin
         state <= state_n;
         cur   <= cur_n;
         tgt   <= tgt_n;
         k     <= k_n;
         found <= found_n;
         shift <= shift_n;
         lr    <= lr_n;
      end
   end
   assign busy = (state == SEARCH);
   assign done = (state == DONE);
endmodule
